// File: rtl/axi_wsched_pkg.sv
// Shared types for the AXI write-order scheduler: W-side FSM states and order FIFO entry layout.
package axi_wsched_pkg;

  localparam int unsigned IDX_W   = 8;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned ENTRY_W = IDX_W + LEN_W;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } w_state_e;

  // idx is sized for up to 256 requesters; the top uses only its low LOG_N_TARG bits.
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [LEN_W-1:0] len;
  } order_entry_t;

endpackage

// File: rtl/axi_wsched_order_fifo.sv
// Synchronous order FIFO holding AW-granted bursts until the W side consumes them.
module axi_wsched_order_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/axi_write_order_scheduler.sv
// Round-robin AW arbiter with in-order W steering for a shared master AW/W channel pair.
// Optional wlast cross-check is built when AXI_WSCHED_LAST_CHECK_EN is defined.
module axi_write_order_scheduler
  import axi_wsched_pkg::*;
#(
  parameter int unsigned N_TARG_PORT = 8,
  parameter int unsigned LOG_N_TARG  = $clog2(N_TARG_PORT),
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_TARG_PORT-1:0]   awvalid_i,
  input  logic [N_TARG_PORT*8-1:0] awlen_i,
  output logic [N_TARG_PORT-1:0]   awready_o,
  output logic                     awvalid_o,
  input  logic                     awready_i,
  output logic [LOG_N_TARG-1:0]    aw_sel_o,
  input  logic [N_TARG_PORT-1:0]   wvalid_i,
  input  logic [N_TARG_PORT-1:0]   wlast_i,
  output logic [N_TARG_PORT-1:0]   wready_o,
  output logic                     wvalid_o,
  output logic                     wlast_o,
  input  logic                     wready_i,
  output logic [LOG_N_TARG-1:0]    w_sel_o,
  output logic [LOG_N_TARG:0]      fifo_count_o,
  output logic                     err_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [LOG_N_TARG-1:0] rr_ptr_q, rr_ptr_d;
  logic                  lock_q;
  logic [LOG_N_TARG-1:0] lock_sel_q;
  logic [LOG_N_TARG-1:0] rr_win, aw_win, cand;
  logic                  rr_found, aw_any, aw_hs;
  logic [7:0]            awlen_arr [N_TARG_PORT];

  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [CNT_W-1:0]      fifo_count;
  order_entry_t          push_entry, head_entry;

  w_state_e              state_q, state_d;
  logic [LOG_N_TARG-1:0] w_sel_q, w_sel_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  cnt_zero, w_beat;

  always_comb begin
    for (int unsigned i = 0; i < N_TARG_PORT; i++) begin
      awlen_arr[i] = awlen_i[i*8 +: 8];
    end
  end

  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    cand     = '0;
    for (int unsigned i = 0; i < N_TARG_PORT; i++) begin
      cand = LOG_N_TARG'((32'(rr_ptr_q) + i) % N_TARG_PORT);
      if (!rr_found && awvalid_i[cand]) begin
        rr_found = 1'b1;
        rr_win   = cand;
      end
    end
  end

  // A stalled AW offer stays pinned to its winner so the master sees a stable request.
  assign aw_win    = lock_q ? lock_sel_q : rr_win;
  assign aw_any    = |awvalid_i;
  assign awvalid_o = aw_any && !fifo_full;
  assign aw_hs     = awvalid_o && awready_i;
  assign aw_sel_o  = aw_win;

  always_comb begin
    awready_o = '0;
    if (aw_hs) awready_o[aw_win] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (aw_hs) begin
      rr_ptr_d = (aw_win == LOG_N_TARG'(N_TARG_PORT - 1)) ? '0 : aw_win + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= awvalid_o && !awready_i;
      lock_sel_q <= aw_win;
    end
  end

  assign push_entry = '{idx: IDX_W'(aw_win), len: awlen_arr[aw_win]};

  axi_wsched_order_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_order_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (aw_hs),
    .wdata_i (push_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head_entry),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign fifo_count_o = (LOG_N_TARG + 1)'(fifo_count);

  assign cnt_zero = (cnt_q == '0);
  assign w_sel_o  = w_sel_q;

  always_comb begin
    state_d  = state_q;
    w_sel_d  = w_sel_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    wvalid_o = 1'b0;
    wlast_o  = 1'b0;
    wready_o = '0;
    w_beat   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          w_sel_d  = head_entry.idx[LOG_N_TARG-1:0];
          cnt_d    = head_entry.len;
          state_d  = BURST;
        end
      end
      BURST: begin
        wvalid_o          = wvalid_i[w_sel_q];
        wready_o[w_sel_q] = wready_i;
        wlast_o           = cnt_zero;
        w_beat            = wvalid_o && wready_i;
        if (w_beat) begin
          if (!cnt_zero) begin
            cnt_d = cnt_q - 1'b1;
          end else if (!fifo_empty) begin
            // Last beat chains straight into the next queued burst without a bubble.
            fifo_pop = 1'b1;
            w_sel_d  = head_entry.idx[LOG_N_TARG-1:0];
            cnt_d    = head_entry.len;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_sel_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      w_sel_q <= w_sel_d;
      cnt_q   <= cnt_d;
    end
  end

  logic unused_head_idx;
  assign unused_head_idx = ^head_entry.idx[IDX_W-1:LOG_N_TARG];

`ifdef AXI_WSCHED_LAST_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (w_beat && (wlast_i[w_sel_q] != cnt_zero)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_wlast;
  assign unused_wlast = ^wlast_i;
  assign err_o        = 1'b0;
`endif

endmodule
